csr_apb_master: RTL and testbench

CSR_APB_MASTER -- requirements
Module: csr_apb_master

---
 rtl/csr_apb_master.sv | 129 ++++++++++++
 tb/tb_csr_apb_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_apb_master.sv
// rtl/csr_apb_master.sv - single-outstanding CSR request to APB3 master bridge
// Define CSR_APB_TIMEOUT_EN to abort ACCESS phases that wait longer than TIMEOUT_CYCLES.
module csr_apb_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h4005_0000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        CSR_REQ,
  input  logic        CSR_WE,
  input  logic [13:0] CSR_A,
  input  logic [31:0] CSR_DW,
  output logic [31:0] CSR_DR,
  output logic        CSR_ACK,
  output logic        CSR_ERR,
  output logic        CSR_BUSY,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state, state_n;
  logic [31:0] paddr_n, pwdata_n, dr_n;
  logic        psel_n, penable_n, pwrite_n, ack_n, err_n, busy_n;
  logic        timeout_hit;

`ifdef CSR_APB_TIMEOUT_EN
  logic [15:0] wait_cnt, wait_cnt_n;
  assign timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (wait_cnt == TIMEOUT_CYCLES);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) wait_cnt <= 16'd0;
    else        wait_cnt <= wait_cnt_n;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // Next values for every output are computed here so all outputs come straight from flops.
  always_comb begin
    state_n   = state;
    paddr_n   = PADDR;
    pwdata_n  = PWDATA;
    pwrite_n  = PWRITE;
    psel_n    = 1'b0;
    penable_n = 1'b0;
    ack_n     = 1'b0;
    err_n     = 1'b0;
    dr_n      = 32'd0;
    busy_n    = 1'b0;
`ifdef CSR_APB_TIMEOUT_EN
    wait_cnt_n = 16'd0;
`endif
    case (state)
      IDLE: begin
        if (CSR_REQ) begin
          state_n  = SETUP;
          paddr_n  = {BASE_ADDR[31:14], CSR_A};
          pwdata_n = CSR_WE ? CSR_DW : 32'd0;
          pwrite_n = CSR_WE;
          psel_n   = 1'b1;
          busy_n   = 1'b1;
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        psel_n    = 1'b1;
        penable_n = 1'b1;
        busy_n    = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_n = IDLE;
          ack_n   = 1'b1;
          err_n   = PSLVERR;
          dr_n    = (!PWRITE && !PSLVERR) ? PRDATA : 32'd0;
        end else if (timeout_hit) begin
          state_n = IDLE;
          ack_n   = 1'b1;
          err_n   = 1'b1;
        end else begin
          psel_n    = 1'b1;
          penable_n = 1'b1;
          busy_n    = 1'b1;
`ifdef CSR_APB_TIMEOUT_EN
          wait_cnt_n = wait_cnt + 16'd1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      PADDR    <= 32'd0;
      PWDATA   <= 32'd0;
      PWRITE   <= 1'b0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      CSR_ACK  <= 1'b0;
      CSR_ERR  <= 1'b0;
      CSR_DR   <= 32'd0;
      CSR_BUSY <= 1'b0;
    end else begin
      state    <= state_n;
      PADDR    <= paddr_n;
      PWDATA   <= pwdata_n;
      PWRITE   <= pwrite_n;
      PSEL     <= psel_n;
      PENABLE  <= penable_n;
      CSR_ACK  <= ack_n;
      CSR_ERR  <= err_n;
      CSR_DR   <= dr_n;
      CSR_BUSY <= busy_n;
    end
  end

endmodule

// File: tb/tb_csr_apb_master.sv
// tb/tb_csr_apb_master.sv - directed self-checking bench for csr_apb_master
// Covers the CSR_APB_TIMEOUT_EN build when that macro is defined.
module tb_csr_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        CSR_REQ, CSR_WE;
  logic [13:0] CSR_A;
  logic [31:0] CSR_DW, CSR_DR;
  logic        CSR_ACK, CSR_ERR, CSR_BUSY;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 PCLK = ~PCLK;

  csr_apb_master #(
    .BASE_ADDR(32'h4005_3FFF),
    .TIMEOUT_CYCLES(16'd4)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .CSR_REQ(CSR_REQ), .CSR_WE(CSR_WE), .CSR_A(CSR_A), .CSR_DW(CSR_DW),
    .CSR_DR(CSR_DR), .CSR_ACK(CSR_ACK), .CSR_ERR(CSR_ERR), .CSR_BUSY(CSR_BUSY),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic request(input logic we, input logic [13:0] a, input logic [31:0] dw);
    CSR_REQ = 1'b1;
    CSR_WE  = we;
    CSR_A   = a;
    CSR_DW  = dw;
  endtask

  initial begin
    PRESET = 1'b1; CSR_REQ = 1'b0; CSR_WE = 1'b0; CSR_A = '0; CSR_DW = '0;
    PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    #1;
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_busy", CSR_BUSY, 0);
    check("rst_ack", CSR_ACK, 0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_dr", CSR_DR, 32'h0);
    tick();
    PRESET = 1'b0;

    // zero-wait write
    request(1'b1, 14'h0010, 32'hDEAD_BEEF);
    tick();
    CSR_REQ = 1'b0;
    check("wr_setup_psel", PSEL, 1);
    check("wr_setup_penable", PENABLE, 0);
    check("wr_setup_busy", CSR_BUSY, 1);
    check("wr_paddr", PADDR, 32'h4005_0010);
    check("wr_pwdata", PWDATA, 32'hDEAD_BEEF);
    check("wr_pwrite", PWRITE, 1);
    tick();
    check("wr_access_penable", PENABLE, 1);
    check("wr_access_ack", CSR_ACK, 0);
    tick();
    check("wr_ack", CSR_ACK, 1);
    check("wr_err", CSR_ERR, 0);
    check("wr_ack_psel", PSEL, 0);
    check("wr_ack_busy", CSR_BUSY, 0);
    tick();
    check("wr_ack_pulse", CSR_ACK, 0);
    check("wr_idle_paddr_hold", PADDR, 32'h4005_0010);

    // read with two wait states
    PREADY = 1'b0; PRDATA = 32'h1234_5678;
    request(1'b0, 14'h0123, 32'hFFFF_FFFF);
    tick();
    CSR_REQ = 1'b0;
    check("rd_pwdata_zero", PWDATA, 32'h0);
    check("rd_pwrite", PWRITE, 0);
    tick();
    tick();
    check("rd_wait1_penable", PENABLE, 1);
    check("rd_wait1_ack", CSR_ACK, 0);
    tick();
    check("rd_wait2_psel", PSEL, 1);
    check("rd_wait2_paddr", PADDR, 32'h4005_0123);
    PREADY = 1'b1;
    tick();
    check("rd_ack", CSR_ACK, 1);
    check("rd_dr", CSR_DR, 32'h1234_5678);
    check("rd_err", CSR_ERR, 0);
    tick();
    check("rd_dr_clear", CSR_DR, 32'h0);

    // read with slave error
    PSLVERR = 1'b1; PRDATA = 32'hAAAA_5555;
    request(1'b0, 14'h0200, 32'h0);
    tick();
    CSR_REQ = 1'b0;
    tick();
    tick();
    check("slv_ack", CSR_ACK, 1);
    check("slv_err", CSR_ERR, 1);
    check("slv_dr", CSR_DR, 32'h0);
    PSLVERR = 1'b0;
    tick();
    check("slv_err_clear", CSR_ERR, 0);

    // request during ACCESS dropped, request in ACK cycle accepted
    PREADY = 1'b0;
    request(1'b1, 14'h0044, 32'h1111_1111);
    tick();
    CSR_REQ = 1'b0;
    tick();
    request(1'b1, 14'h0099, 32'h2222_2222);
    tick();
    CSR_REQ = 1'b0;
    check("drop_paddr", PADDR, 32'h4005_0044);
    check("drop_pwdata", PWDATA, 32'h1111_1111);
    PREADY = 1'b1;
    tick();
    check("drop_ack", CSR_ACK, 1);
    check("b2b_ack_psel", PSEL, 0);
    request(1'b0, 14'h0077, 32'h0);
    tick();
    CSR_REQ = 1'b0;
    check("b2b_setup_psel", PSEL, 1);
    check("b2b_setup_penable", PENABLE, 0);
    check("b2b_paddr", PADDR, 32'h4005_0077);
    check("b2b_ack_gone", CSR_ACK, 0);
    tick();
    tick();
    check("b2b_ack", CSR_ACK, 1);
    tick();
    check("no_queued_req", PSEL, 0);

    // reset during ACCESS
    PREADY = 1'b0;
    request(1'b1, 14'h0300, 32'h3333_3333);
    tick();
    CSR_REQ = 1'b0;
    tick();
    check("rstmid_penable_before", PENABLE, 1);
    #2 PRESET = 1'b1;
    #1;
    check("rstmid_psel", PSEL, 0);
    check("rstmid_penable", PENABLE, 0);
    check("rstmid_paddr", PADDR, 32'h0);
    PREADY = 1'b1;
    tick();
    check("rstmid_no_ack", CSR_ACK, 0);
    PRESET = 1'b0;
    request(1'b1, 14'h0001, 32'h0000_0005);
    tick();
    CSR_REQ = 1'b0;
    check("post_rst_accept", PSEL, 1);
    check("post_rst_ack", CSR_ACK, 0);
    tick();
    tick();
    check("post_rst_done", CSR_ACK, 1);
    tick();

    // stalled slave
    PREADY = 1'b0; PRDATA = 32'hCAFE_F00D;
    request(1'b0, 14'h0abc, 32'h0);
    tick();
    CSR_REQ = 1'b0;
    tick();
`ifdef CSR_APB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_wait_ack", CSR_ACK, 0);
      check("to_wait_psel", PSEL, 1);
    end
    tick();
    check("to_ack", CSR_ACK, 1);
    check("to_err", CSR_ERR, 1);
    check("to_dr", CSR_DR, 32'h0);
    check("to_psel", PSEL, 0);
    check("to_penable", PENABLE, 0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_ack", CSR_ACK, 0);
      check("stall_penable", PENABLE, 1);
    end
    PREADY = 1'b1;
    tick();
    check("stall_ack_end", CSR_ACK, 1);
    check("stall_dr", CSR_DR, 32'hCAFE_F00D);
`endif
    tick();
    check("final_idle_busy", CSR_BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
